// File: rtl/operand_router_pkg.sv
// Shared constants for the operand router: immediate codes and select-code layout.
package operand_router_pkg;

    // Immediate select codes
    localparam logic [1:0] SEL_I_ZERO   = 2'b00;
    localparam logic [1:0] SEL_I_PLUS1  = 2'b01;
    localparam logic [1:0] SEL_I_MINUS1 = 2'b10;
    localparam logic [1:0] SEL_I_RSVD   = 2'b11;

    // Select-code positions that follow the NSRC bank ports
    typedef struct packed {
        logic [31:0] temp;
        logic [31:0] zero;
        logic [31:0] ones;
    } sel_offsets_t;

    // Returns the temp/zero/all-ones select codes for a given bank port count
    function automatic sel_offsets_t sel_offsets(input int unsigned nsrc);
        sel_offsets_t offs;
        offs.temp = 32'(nsrc);
        offs.zero = 32'(nsrc + 32'd1);
        offs.ones = 32'(nsrc + 32'd2);
        return offs;
    endfunction

endpackage

// File: rtl/operand_router_mux.sv
// One operand path: pick a bank word, the temp register (with writeback
// forwarding), or a constant, then optionally invert it.
module operand_mux
    import operand_router_pkg::*;
#(
    parameter int W    = 24,
    parameter int NSRC = 4,
    parameter int SELW = $clog2(NSRC + 3)
) (
    input  logic [NSRC*W-1:0] src_data,
    input  logic [SELW-1:0]   sel,
    input  logic              inv,
    input  logic [W-1:0]      temp_val,
    input  logic              ld,
    input  logic              clr,
    input  logic [W-1:0]      au_result,
    output logic [W-1:0]      operand
);

    localparam sel_offsets_t OFFS = sel_offsets(NSRC);
    localparam logic [SELW-1:0] SEL_TEMP = SELW'(OFFS.temp);
    localparam logic [SELW-1:0] SEL_ZERO = SELW'(OFFS.zero);
    localparam logic [SELW-1:0] SEL_ONES = SELW'(OFFS.ones);

    logic [W-1:0] src_word_s;
    logic [W-1:0] fwd_word_s;
    logic [W-1:0] sel_word_s;

    // Bank word addressed by the select code (zero when code is not a bank port)
    always_comb begin
        src_word_s = {W{1'b0}};
        for (int k = 0; k < NSRC; k++) begin
            if (sel == SELW'(k)) begin
                src_word_s = src_data[k*W +: W];
            end else begin
                src_word_s = src_word_s;
            end
        end
    end

    // Temp value as it will be after this edge: clear beats load beats hold
    always_comb begin
        if (clr) begin
            fwd_word_s = {W{1'b0}};
        end else if (ld) begin
            fwd_word_s = au_result;
        end else begin
            fwd_word_s = temp_val;
        end
    end

    // Select first, invert second; reserved codes fall through to zero
    always_comb begin
        sel_word_s = {W{1'b0}};
        if (sel < SELW'(NSRC)) begin
            sel_word_s = src_word_s;
        end else if (sel == SEL_TEMP) begin
            sel_word_s = fwd_word_s;
        end else if (sel == SEL_ZERO) begin
            sel_word_s = {W{1'b0}};
        end else if (sel == SEL_ONES) begin
            sel_word_s = {W{1'b1}};
        end else begin
            sel_word_s = {W{1'b0}};
        end
        operand = inv ? ~sel_word_s : sel_word_s;
    end

endmodule

// File: rtl/operand_router.sv
// Operand router: builds registered R/S/I operands for the AU behind a
// valid/ready stage and holds the RQ/RD writeback temp registers.
module operand_router
    import operand_router_pkg::*;
#(
    parameter int W    = 24,
    parameter int NSRC = 4,
    parameter int SELW = $clog2(NSRC + 3)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSRC*W-1:0] src_data,
    input  logic [SELW-1:0]   sel_R,
    input  logic [SELW-1:0]   sel_S,
    input  logic              inv_R,
    input  logic              inv_S,
    input  logic [1:0]        sel_I,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      au_result,
    input  logic              ld_q,
    input  logic              ld_d,
    input  logic              clr_q,
    input  logic              clr_d,
    output logic [W-1:0]      R,
    output logic [W-1:0]      S,
    output logic [W-1:0]      I,
    output logic              msb_R,
    output logic              msb_S,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      rq,
    output logic [W-1:0]      rd
);

    logic [W-1:0] r_r, s_r, i_r, rq_r, rd_r;
    logic         msb_r_r, msb_s_r, out_valid_r;
    logic [W-1:0] r_next_s, s_next_s, i_next_s;
    logic         accept_s;

    operand_mux #(.W(W), .NSRC(NSRC), .SELW(SELW)) u_mux_r (
        .src_data  (src_data),
        .sel       (sel_R),
        .inv       (inv_R),
        .temp_val  (rq_r),
        .ld        (ld_q),
        .clr       (clr_q),
        .au_result (au_result),
        .operand   (r_next_s)
    );

    operand_mux #(.W(W), .NSRC(NSRC), .SELW(SELW)) u_mux_s (
        .src_data  (src_data),
        .sel       (sel_S),
        .inv       (inv_S),
        .temp_val  (rd_r),
        .ld        (ld_d),
        .clr       (clr_d),
        .au_result (au_result),
        .operand   (s_next_s)
    );

    // Ready when the output slot is empty or draining this cycle
    always_comb begin
        in_ready = !out_valid_r || out_ready;
        accept_s = in_valid && in_ready;
    end

    // Immediate operand decode
    always_comb begin
        case (sel_I)
            SEL_I_ZERO:   i_next_s = {W{1'b0}};
            SEL_I_PLUS1:  i_next_s = W'(1);
            SEL_I_MINUS1: i_next_s = {W{1'b1}};
            SEL_I_RSVD:   i_next_s = {W{1'b0}};
            default:      i_next_s = {W{1'b0}};
        endcase
    end

    // Output stage: load on accept, hold under backpressure, drop valid after transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_r         <= {W{1'b0}};
            s_r         <= {W{1'b0}};
            i_r         <= {W{1'b0}};
            msb_r_r     <= 1'b0;
            msb_s_r     <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (accept_s) begin
            r_r         <= r_next_s;
            s_r         <= s_next_s;
            i_r         <= i_next_s;
            msb_r_r     <= r_next_s[W-1];
            msb_s_r     <= s_next_s[W-1];
            out_valid_r <= 1'b1;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    // Temp registers update every cycle regardless of the handshake; clear wins
    always_ff @(posedge clk) begin
        if (rst) begin
            rq_r <= {W{1'b0}};
            rd_r <= {W{1'b0}};
        end else begin
            if (clr_q) begin
                rq_r <= {W{1'b0}};
            end else if (ld_q) begin
                rq_r <= au_result;
            end
            if (clr_d) begin
                rd_r <= {W{1'b0}};
            end else if (ld_d) begin
                rd_r <= au_result;
            end
        end
    end

    assign R         = r_r;
    assign S         = s_r;
    assign I         = i_r;
    assign msb_R     = msb_r_r;
    assign msb_S     = msb_s_r;
    assign out_valid = out_valid_r;
    assign rq        = rq_r;
    assign rd        = rd_r;

endmodule

// File: tb/tb_operand_router.sv
// Self-checking bench for operand_router: directed scenarios followed by
// random traffic, all compared against a behavioural reference model.
module tb_operand_router;

    localparam int W    = 24;
    localparam int NSRC = 4;
    localparam int SELW = $clog2(NSRC + 3);

    logic              clk = 1'b0;
    logic              rst;
    logic [NSRC*W-1:0] src_data;
    logic [SELW-1:0]   sel_R, sel_S;
    logic              inv_R, inv_S;
    logic [1:0]        sel_I;
    logic              in_valid, in_ready;
    logic [W-1:0]      au_result;
    logic              ld_q, ld_d, clr_q, clr_d;
    logic [W-1:0]      R, S, I;
    logic              msb_R, msb_S, out_valid, out_ready;
    logic [W-1:0]      rq, rd;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [W-1:0] m_R = '0, m_S = '0, m_I = '0, m_rq = '0, m_rd = '0;
    logic         m_ov = 1'b0;

    always #5 clk = ~clk;

    operand_router #(.W(W), .NSRC(NSRC)) dut (
        .clk(clk), .rst(rst), .src_data(src_data),
        .sel_R(sel_R), .sel_S(sel_S), .inv_R(inv_R), .inv_S(inv_S),
        .sel_I(sel_I), .in_valid(in_valid), .in_ready(in_ready),
        .au_result(au_result), .ld_q(ld_q), .ld_d(ld_d),
        .clr_q(clr_q), .clr_d(clr_d), .R(R), .S(S), .I(I),
        .msb_R(msb_R), .msb_S(msb_S), .out_valid(out_valid),
        .out_ready(out_ready), .rq(rq), .rd(rd)
    );

    function automatic logic [W-1:0] pick(input int sel, input logic [W-1:0] tmp);
        if (sel < NSRC)           return src_data[sel*W +: W];
        else if (sel == NSRC)     return tmp;
        else if (sel == NSRC + 2) return '1;
        else                      return '0;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".R"}, R, m_R);
        chk({tag, ".S"}, S, m_S);
        chk({tag, ".I"}, I, m_I);
        chk({tag, ".msb_R"}, W'(msb_R), W'(m_R[W-1]));
        chk({tag, ".msb_S"}, W'(msb_S), W'(m_S[W-1]));
        chk({tag, ".out_valid"}, W'(out_valid), W'(m_ov));
        chk({tag, ".rq"}, rq, m_rq);
        chk({tag, ".rd"}, rd, m_rd);
        chk({tag, ".in_ready"}, W'(in_ready), W'(!m_ov || out_ready));
    endtask

    // One clock: model predicts from pre-edge inputs, then the DUT is compared
    task automatic cycle(input string tag);
        logic [W-1:0] nrq, nrd, nR, nS, nI, vr, vs;
        logic         nov;
        nR = m_R; nS = m_S; nI = m_I; nov = m_ov;
        if (rst) begin
            nrq = '0; nrd = '0; nR = '0; nS = '0; nI = '0; nov = 1'b0;
        end else begin
            nrq = clr_q ? '0 : (ld_q ? au_result : m_rq);
            nrd = clr_d ? '0 : (ld_d ? au_result : m_rd);
            if (in_valid && (!m_ov || out_ready)) begin
                // a temp selected here sees the value the temp takes at this edge
                vr = pick(int'(sel_R), nrq);
                vs = pick(int'(sel_S), nrd);
                nR = inv_R ? ~vr : vr;
                nS = inv_S ? ~vs : vs;
                nI = (sel_I == 2'd1) ? W'(1) : ((sel_I == 2'd2) ? '1 : '0);
                nov = 1'b1;
            end else if (m_ov && out_ready) begin
                nov = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        m_R = nR; m_S = nS; m_I = nI; m_ov = nov; m_rq = nrq; m_rd = nrd;
        check_all(tag);
    endtask

    task automatic idle();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        ld_q = 1'b0; ld_d = 1'b0; clr_q = 1'b0; clr_d = 1'b0;
        sel_R = '0; sel_S = '0; inv_R = 1'b0; inv_S = 1'b0; sel_I = 2'b00;
    endtask

    task automatic randomize_req();
        src_data  = {$urandom(), $urandom(), $urandom()};
        sel_R     = SELW'($urandom_range(0, 7));
        sel_S     = SELW'($urandom_range(0, 7));
        inv_R     = 1'($urandom_range(0, 1));
        inv_S     = 1'($urandom_range(0, 1));
        sel_I     = 2'($urandom_range(0, 3));
        au_result = W'($urandom());
    endtask

    logic [W-1:0] held_R, held_S, held_I;

    initial begin
        idle();
        src_data = '0; au_result = '0;

        // Reset with junk on every control input
        rst = 1'b1; in_valid = 1'b1; ld_q = 1'b1; ld_d = 1'b1; au_result = 24'h5A5A5A;
        sel_R = 3'd6; sel_S = 3'd6;
        @(posedge clk); #1;
        cycle("reset");
        idle();
        #1;
        chk("reset.R0", R, 24'h000000);
        chk("reset.in_ready", W'(in_ready), 24'h000001);
        chk("reset.rq0", rq, 24'h000000);

        // Basic select/invert/immediate
        src_data[2*W +: W] = 24'h123456;
        src_data[3*W +: W] = 24'hABCDEF;
        sel_R = 3'd2; sel_S = 3'd3; inv_S = 1'b1; sel_I = 2'b01; in_valid = 1'b1;
        cycle("basic");
        chk("basic.R", R, 24'h123456);
        chk("basic.S", S, 24'h543210);
        chk("basic.I", I, 24'h000001);

        // Backpressure: new requests must not disturb the held output
        held_R = R; held_S = S; held_I = I;
        out_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            randomize_req();
            cycle("bp");
            chk("bp.hold_R", R, held_R);
            chk("bp.hold_S", S, held_S);
            chk("bp.hold_I", I, held_I);
            chk("bp.in_ready", W'(in_ready), 24'h000000);
        end
        out_ready = 1'b1;
        src_data[0 +: W] = 24'h00C0DE;
        sel_R = 3'd0; sel_S = 3'd6; inv_R = 1'b0; inv_S = 1'b0; sel_I = 2'b10;
        cycle("bp_release");
        chk("bp_release.R", R, 24'h00C0DE);
        chk("bp_release.I", I, 24'hFFFFFF);
        chk("bp_release.ov", W'(out_valid), 24'h000001);

        // Forwarding RQ writeback into R
        idle();
        ld_q = 1'b1; au_result = 24'h000010;
        cycle("fwd_pre");
        in_valid = 1'b1; sel_R = 3'd4; au_result = 24'h0000FF;
        cycle("fwd");
        chk("fwd.R", R, 24'h0000FF);
        chk("fwd.rq", rq, 24'h0000FF);

        // Clear beats load on RD, and the forwarded S sees zero
        idle();
        in_valid = 1'b1; ld_d = 1'b1; clr_d = 1'b1; sel_S = 3'd4; au_result = 24'h777777;
        sel_R = 3'd5;
        cycle("clr");
        chk("clr.S", S, 24'h000000);
        chk("clr.rd", rd, 24'h000000);
        chk("clr.R5", R, 24'h000000);
        ld_d = 1'b0; clr_d = 1'b0;
        sel_R = 3'd6;
        cycle("ones");
        chk("ones.R", R, 24'hFFFFFF);
        chk("ones.msb_R", W'(msb_R), 24'h000001);
        sel_R = 3'd7;
        cycle("rsvd");
        chk("rsvd.R", R, 24'h000000);

        // Reset while an output is pending and a load is requested
        idle();
        in_valid = 1'b1; sel_R = 3'd6;
        cycle("mid_fill");
        in_valid = 1'b0; out_ready = 1'b0;
        cycle("mid_hold");
        rst = 1'b1; ld_q = 1'b1; au_result = 24'h123123; in_valid = 1'b1;
        cycle("mid_rst");
        chk("mid_rst.ov", W'(out_valid), 24'h000000);
        chk("mid_rst.rq", rq, 24'h000000);
        chk("mid_rst.R", R, 24'h000000);

        // Random traffic against the model
        idle();
        for (int n = 0; n < 400; n++) begin
            randomize_req();
            rst       = ($urandom_range(0, 49) == 0);
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            ld_q      = 1'($urandom_range(0, 1));
            ld_d      = 1'($urandom_range(0, 1));
            clr_q     = ($urandom_range(0, 5) == 0);
            clr_d     = ($urandom_range(0, 5) == 0);
            cycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
